// File: rtl/shift_req_queue_if.sv
// rtl/shift_req_queue_if.sv - request, shifter and result signals of shift_req_queue
// slave is the queue side; master is the producer/consumer/shifter side.
interface shift_req_queue_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               in_data;
  logic [2:0]               in_shamt;
  logic [7:0]               sh_a;
  logic [2:0]               sh_k;
  logic [7:0]               sh_result;
  logic                     out_valid;
  logic                     out_ready;
  logic [7:0]               out_data;
  logic [2:0]               out_shamt;
  logic [$clog2(DEPTH):0]   level;

  modport slave (
    input  in_valid, in_data, in_shamt, sh_result, out_ready,
    output in_ready, sh_a, sh_k, out_valid, out_data, out_shamt, level
  );

  modport master (
    output in_valid, in_data, in_shamt, sh_result, out_ready,
    input  in_ready, sh_a, sh_k, out_valid, out_data, out_shamt, level
  );
endinterface

// File: rtl/shift_req_queue.sv
// rtl/shift_req_queue.sv - FIFO front end and output register around an external right shifter
// Head entry feeds the shifter combinationally; its result is captured on pop.
module shift_req_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_req_queue_if.slave  bus
);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(DEPTH);

  logic [10:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level_q;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic [2:0]       out_shamt_q;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [10:0]      head;

  // Full/empty come from the occupancy count, so pointers may wrap freely.
  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LVL_FULL);
    head  = mem[rd_ptr];
    push  = bus.in_valid && !full;
    pop   = !empty && (!out_valid_q || bus.out_ready);
  end

  assign bus.in_ready  = !full;
  assign bus.sh_a      = empty ? 8'h00 : head[10:3];
  assign bus.sh_k      = empty ? 3'd0  : head[2:0];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_shamt = out_shamt_q;
  assign bus.level     = level_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_data, bus.in_shamt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_shamt_q <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        out_valid_q <= 1'b1;
        out_data_q  <= bus.sh_result;
        out_shamt_q <= head[2:0];
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_req_queue.sv
// tb/tb_shift_req_queue.sv - self-checking bench for shift_req_queue
// A queue-level reference model is compared against the DUT on every falling edge.
module tb_shift_req_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] k;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  shift_req_queue_if #(.DEPTH(DEPTH)) bus();

  shift_req_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External combinational shifter.
  assign bus.sh_result = bus.sh_a >> bus.sh_k;

  always #5 clk = ~clk;

  req_t       mq[$];
  logic       m_ov = 1'b0;
  logic [7:0] m_od = 8'h00;
  logic [2:0] m_ok = 3'd0;
  logic [7:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ov <= 1'b0;
      m_od <= 8'h00;
      m_ok <= 3'd0;
    end else begin
      bit   pu;
      bit   po;
      req_t h;
      pu = bus.in_valid && (mq.size() < DEPTH);
      po = (mq.size() > 0) && (!m_ov || bus.out_ready);
      if (po) begin
        h = mq.pop_front();
        m_od <= h.d >> h.k;
        m_ok <= h.k;
        m_ov <= 1'b1;
      end else if (m_ov && bus.out_ready) begin
        m_ov <= 1'b0;
      end
      if (pu) mq.push_back({bus.in_data, bus.in_shamt});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready",  32'(bus.in_ready),  32'(mq.size() < DEPTH));
      check("level",     32'(bus.level),     32'(mq.size()));
      check("out_valid", 32'(bus.out_valid), 32'(m_ov));
      check("out_data",  32'(bus.out_data),  32'(m_od));
      check("out_shamt", 32'(bus.out_shamt), 32'(m_ok));
      check("sh_a",      32'(bus.sh_a),      (mq.size() > 0) ? 32'(mq[0].d) : 32'd0);
      check("sh_k",      32'(bus.sh_k),      (mq.size() > 0) ? 32'(mq[0].k) : 32'd0);
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] k);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = k;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) check("send_timeout", 32'(n), 32'd0);
    step();
  endtask

  task automatic drain(input int n);
    int c;
    c = 0;
    while (got.size() < n && c < 40) begin
      step();
      c++;
    end
    if (c >= 40) check("drain_timeout", 32'(got.size()), 32'(n));
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] bp_exp[6];
    logic [7:0] d;
    logic [2:0] k;

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_shamt  = 3'd0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    check("reset_level",     32'(bus.level),     32'd0);
    check("reset_in_ready",  32'(bus.in_ready),  32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data",  32'(bus.out_data),  32'h00);

    // Single request: result one cycle after accept.
    bus.out_ready = 1'b1;
    send(8'hB4, 3'd2);
    bus.in_valid = 1'b0;
    step();
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_data",  32'(bus.out_data),  32'h2D);
    check("single_shamt", 32'(bus.out_shamt), 32'd2);
    step();

    // Corner shift amounts.
    got.delete();
    send(8'hFF, 3'd0);
    send(8'h80, 3'd7);
    send(8'h7F, 3'd7);
    bus.in_valid = 1'b0;
    drain(3);
    check("corner_cnt", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("corner_ff_k0", 32'(got[0]), 32'hFF);
      check("corner_80_k7", 32'(got[1]), 32'h01);
      check("corner_7f_k7", 32'(got[2]), 32'h00);
    end

    // Backpressure until full, then release.
    got.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 3'd1);
    bus.in_data = 8'h15;
    for (int i = 0; i < 3; i++) begin
      check("full_in_ready", 32'(bus.in_ready),  32'd0);
      check("full_level",    32'(bus.level),     32'd4);
      check("stall_valid",   32'(bus.out_valid), 32'd1);
      check("stall_data",    32'(bus.out_data),  32'h08);
      step();
    end
    bus.out_ready = 1'b1;
    send(8'h15, 3'd1);
    bus.in_valid = 1'b0;
    drain(6);
    bp_exp = '{8'h08, 8'h08, 8'h09, 8'h09, 8'h0A, 8'h0A};
    check("bp_cnt", 32'(got.size()), 32'd6);
    if (got.size() == 6) begin
      for (int i = 0; i < 6; i++) check("bp_order", 32'(got[i]), 32'(bp_exp[i]));
    end

    // Streaming with both sides always ready.
    got.delete();
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      k = 3'($urandom_range(0, 7));
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_shamt = k;
      if (bus.in_ready) exp_q.push_back(d >> k);
      step();
    end
    bus.in_valid = 1'b0;
    check("stream_accepts", 32'(exp_q.size()), 32'd16);
    drain(exp_q.size());
    check("stream_cnt", 32'(got.size()), 32'(exp_q.size()));
    if (got.size() == exp_q.size()) begin
      foreach (exp_q[i]) check("stream_order", 32'(got[i]), 32'(exp_q[i]));
    end

    // Reset mid-operation.
    got.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), 3'd0);
    bus.in_valid = 1'b0;
    check("preload_level", 32'(bus.level),     32'd3);
    check("preload_valid", 32'(bus.out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_level",     32'(bus.level),     32'd0);
    check("async_in_ready",  32'(bus.in_ready),  32'd1);
    check("async_out_data",  32'(bus.out_data),  32'h00);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("no_stale_valid", 32'(bus.out_valid), 32'd0);
    check("no_stale_out",   32'(got.size()),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
